// File: rtl/secure_reg_access_ctrl_if.sv
// Requester and protected-register bundle for secure_reg_access_ctrl.
// The master side is the requesters plus register model; the slave side is the controller.
interface secure_reg_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int NREQ   = 4
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        priv;
  logic [2*NREQ-1:0]      op;
  logic [DATA_W*NREQ-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   err;
  logic [DATA_W-1:0]      rdata;
  logic                   reg_we;
  logic [DATA_W-1:0]      reg_wdata;
  logic [DATA_W-1:0]      reg_rdata;
  logic                   locked;
  logic                   lockout;

  modport master (
    output req, priv, op, wdata, reg_rdata,
    input  gnt, done, err, rdata, reg_we, reg_wdata, locked, lockout
  );

  modport slave (
    input  req, priv, op, wdata, reg_rdata,
    output gnt, done, err, rdata, reg_we, reg_wdata, locked, lockout
  );
endinterface

// File: rtl/secure_reg_access_ctrl.sv
// Round-robin, lock-policed access controller in front of a single protected data register.
// Each access takes IDLE -> EXEC -> RESP; only permitted writes ever strobe reg_we.
module secure_reg_access_ctrl #(
  parameter int                DATA_W        = 32,
  parameter int                NREQ          = 4,
  parameter logic [DATA_W-1:0] KEY           = 32'hA5C3_0F1E,
  parameter bit                LOCK_ON_RESET = 1'b1,
  parameter int                MAX_FAIL      = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  secure_reg_access_ctrl_if.slave bus
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_LOCK   = 2'b10;
  localparam logic [1:0] OP_UNLOCK = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, next_state;
  logic [PTR_W-1:0]   rr_ptr, idx, winner, cand;
  logic               win_found;
  logic [NREQ-1:0]    sel_onehot;
  logic [1:0]         cur_op;
  logic               cur_priv;
  logic [DATA_W-1:0]  cur_wdata;
  logic               rw_ok, unlock_ok, do_write, write_now, acc_err;
  logic [DATA_W-1:0]  acc_rdata;
  logic               err_q, locked_q, lockout_q;
  logic [DATA_W-1:0]  rdata_q, wdata_hold;
  logic [FAIL_W-1:0]  fail_cnt;

  // First requesting index at or after rr_ptr, wrapping; lower k overrides later hits.
  always_comb begin
    winner    = rr_ptr;
    win_found = 1'b0;
    cand      = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NREQ);
      if (bus.req[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    cur_op    = OP_READ;
    cur_priv  = 1'b0;
    cur_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == PTR_W'(i)) begin
        cur_op    = bus.op[2*i +: 2];
        cur_priv  = bus.priv[i];
        cur_wdata = bus.wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign sel_onehot = NREQ'(1) << idx;
  assign rw_ok      = cur_priv || !locked_q;
  assign unlock_ok  = cur_priv && !lockout_q && (cur_wdata == KEY);

  always_comb begin
    acc_err   = 1'b0;
    acc_rdata = '0;
    do_write  = 1'b0;
    case (cur_op)
      OP_READ: begin
        if (rw_ok) acc_rdata = bus.reg_rdata;
        else       acc_err   = 1'b1;
      end
      OP_WRITE: begin
        if (rw_ok) do_write = 1'b1;
        else       acc_err  = 1'b1;
      end
      OP_LOCK:  acc_err = !cur_priv;
      default:  acc_err = !unlock_ok;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    bus.gnt    = '0;
    bus.done   = '0;
    write_now  = 1'b0;
    case (state)
      IDLE: if (win_found) next_state = EXEC;
      EXEC: begin
        next_state = RESP;
        bus.gnt    = sel_onehot;
        write_now  = do_write;
      end
      RESP: begin
        next_state = IDLE;
        bus.gnt    = sel_onehot;
        bus.done   = sel_onehot;
      end
      default: next_state = IDLE;
    endcase
  end

  // Denied writes leave reg_wdata showing the last permitted value.
  assign bus.reg_we    = write_now;
  assign bus.reg_wdata = write_now ? cur_wdata : wdata_hold;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.locked    = locked_q;
  assign bus.lockout   = lockout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      idx        <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      wdata_hold <= '0;
      locked_q   <= LOCK_ON_RESET;
      lockout_q  <= 1'b0;
      fail_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            idx    <= winner;
            rr_ptr <= PTR_W'((int'(winner) + 1) % NREQ);
          end
        end
        EXEC: begin
          err_q   <= acc_err;
          rdata_q <= acc_rdata;
          if (do_write) wdata_hold <= cur_wdata;
          if (cur_op == OP_LOCK && cur_priv) locked_q <= 1'b1;
          if (cur_op == OP_UNLOCK) begin
            if (unlock_ok) begin
              locked_q <= 1'b0;
              fail_cnt <= '0;
            end else if (cur_priv && !lockout_q) begin
              // Only privileged wrong-key attempts count toward permanent lockout.
              fail_cnt <= fail_cnt + FAIL_W'(1);
              if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
                lockout_q <= 1'b1;
                locked_q  <= 1'b1;
              end
            end
          end
        end
        RESP: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
